// File: rtl/count_sequencer_pkg.sv
// count_seq_pkg: state encoding and default parameters shared by the
// count_sequencer slice (package, interface, prescaler and top).
package count_seq_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PRESCALE   = 4;
  localparam int DEF_SETTLE_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: control/status bundle between the system control logic,
// the sequenced counter and count_sequencer. The sequencer uses the slave view.
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] count_in;
  logic             count_enable;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   steps_left;
  logic             err;

  modport master (
    output start, abort, target, count_in,
    input  count_enable, busy, done, steps_left, err
  );

  modport slave (
    input  start, abort, target, count_in,
    output count_enable, busy, done, steps_left, err
  );

endinterface

// File: rtl/count_sequencer_enable_prescaler.sv
// enable_prescaler: modulo-PRESCALE counter. tick reports that the counter
// will hold its terminal count in the coming cycle, so a register fed by tick
// is high exactly while the counter sits at PRESCALE-1.
module enable_prescaler
  import count_seq_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clock,
  input  logic reset_N,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Next count: clear wins, otherwise step and wrap while running, else hold.
  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt_next == LAST);

  // Prescale count register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: drives a WIDTH-bit counter's count_enable from its current
// value up to a latched target, one pulse every PRESCALE cycles, then waits
// SETTLE_CYC cycles and reports done. Optional macro COUNT_CHECK_EN adds the
// sticky err flag for a settled count that misses the target.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input logic              clock,
  input logic              reset_N,
  count_sequencer_if.slave bus
);

  localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [WIDTH:0] FULL_REV    = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE_STEP    = (WIDTH + 1)'(1);

  seq_state_t       state;
  logic [WIDTH-1:0] target_lat;
  logic [WIDTH-1:0] distance;
  logic [WIDTH:0]   steps;
  logic [SW-1:0]    settle_cnt;
  logic             count_enable_r;
  logic             busy_r;
  logic             done_r;
  logic             presc_clear;
  logic             presc_run;
  logic             presc_tick;

  // The prescaler only advances in RUN; everywhere else (and on abort) it is
  // held at zero so the first pulse of a run lands PRESCALE-1 cycles in.
  assign presc_run   = (state == ST_RUN);
  assign presc_clear = !presc_run || bus.abort;
  assign distance    = target_lat - bus.count_in;

  enable_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_N (reset_N),
    .clear   (presc_clear),
    .run     (presc_run),
    .tick    (presc_tick)
  );

  // Sequencing FSM; every output is registered together with the state.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state          <= ST_IDLE;
      target_lat     <= '0;
      steps          <= '0;
      settle_cnt     <= '0;
      count_enable_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            target_lat <= bus.target;
            busy_r     <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            steps  <= '0;
          end else begin
            // Equal start and target means one full revolution.
            steps          <= (distance == '0) ? FULL_REV : {1'b0, distance};
            count_enable_r <= presc_tick;
            state          <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state          <= ST_IDLE;
            busy_r         <= 1'b0;
            steps          <= '0;
            count_enable_r <= 1'b0;
          end else if (count_enable_r && steps == ONE_STEP) begin
            steps          <= '0;
            count_enable_r <= 1'b0;
            settle_cnt     <= '0;
            state          <= ST_SETTLE;
          end else begin
            if (count_enable_r) begin
              steps <= steps - 1'b1;
            end
            count_enable_r <= presc_tick;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            steps  <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef COUNT_CHECK_EN
  logic err_r;

  // Sticky mismatch flag: cleared by an accepted start, set when the settled
  // count differs from the latched target on the way into DONE.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      err_r <= 1'b0;
    end else if (state == ST_IDLE && bus.start && !bus.abort) begin
      err_r <= 1'b0;
    end else if (state == ST_SETTLE && !bus.abort && settle_cnt == SETTLE_LAST &&
                 bus.count_in != target_lat) begin
      err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.count_enable = count_enable_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.steps_left   = steps;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: two sequencers (PRESCALE=4 and PRESCALE=1), each with a
// behavioural counter in the loop. Expected per-cycle outputs come from the
// run timeline (LOAD, N*P RUN cycles, SETTLE, DONE) computed arithmetically.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int W = 4;
  localparam int S = 2;

  logic clock = 1'b0;
  logic reset_N = 1'b0;
  always #5 clock = ~clock;

  count_sequencer_if #(.WIDTH(W)) bus4 ();
  count_sequencer_if #(.WIDTH(W)) bus1 ();

  count_sequencer #(.WIDTH(W), .PRESCALE(4), .SETTLE_CYC(S)) dut4 (
    .clock(clock), .reset_N(reset_N), .bus(bus4));
  count_sequencer #(.WIDTH(W), .PRESCALE(1), .SETTLE_CYC(S)) dut1 (
    .clock(clock), .reset_N(reset_N), .bus(bus1));

  logic         start_s [2];
  logic         abort_s [2];
  logic [W-1:0] target_s[2];
  logic [W-1:0] cnt     [2];
  logic         load_req[2];
  logic [W-1:0] load_val[2];
  int           drop_idx[2];
  int           pulse_idx[2];

  logic         en_o   [2];
  logic         busy_o [2];
  logic         done_o [2];
  logic         err_o  [2];
  logic [W:0]   steps_o[2];

  assign bus4.start    = start_s[0];
  assign bus4.abort    = abort_s[0];
  assign bus4.target   = target_s[0];
  assign bus4.count_in = cnt[0];
  assign bus1.start    = start_s[1];
  assign bus1.abort    = abort_s[1];
  assign bus1.target   = target_s[1];
  assign bus1.count_in = cnt[1];

  assign en_o[0]    = bus4.count_enable;
  assign busy_o[0]  = bus4.busy;
  assign done_o[0]  = bus4.done;
  assign err_o[0]   = bus4.err;
  assign steps_o[0] = bus4.steps_left;
  assign en_o[1]    = bus1.count_enable;
  assign busy_o[1]  = bus1.busy;
  assign done_o[1]  = bus1.done;
  assign err_o[1]   = bus1.err;
  assign steps_o[1] = bus1.steps_left;

  // Counter models: +1 on each enable, except the pulse numbered drop_idx.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (load_req[i]) begin
        cnt[i]       <= load_val[i];
        pulse_idx[i] <= 0;
      end else if (en_o[i]) begin
        if (pulse_idx[i] != drop_idx[i]) cnt[i] <= cnt[i] + 1'b1;
        pulse_idx[i] <= pulse_idx[i] + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check_eq({tag, " en"},    32'(en_o[sel]),    0);
    check_eq({tag, " busy"},  32'(busy_o[sel]),  0);
    check_eq({tag, " done"},  32'(done_o[sel]),  0);
    check_eq({tag, " steps"}, 32'(steps_o[sel]), 0);
  endtask

  // One complete run: preload the counter, start, check every cycle.
  task automatic do_run(input int sel, input int init, input int tgt, input int abort_at,
                        input int drop_at, input bit hold_start, input string name);
    int   p, n, last, final_cnt, exp_en, exp_steps;
    bit   aborted;
    logic exp_err;
    p = (sel == 0) ? 4 : 1;
    n = (tgt - init) & ((1 << W) - 1);
    if (n == 0) n = 1 << W;
    last = n * p + S + 1;
    final_cnt = (init + n - ((drop_at >= 0 && drop_at < n) ? 1 : 0)) & ((1 << W) - 1);
`ifdef COUNT_CHECK_EN
    exp_err = (final_cnt != tgt);
`else
    exp_err = 1'b0;
`endif
    $display("run %s sel=%0d init=%0d tgt=%0d n=%0d abort_at=%0d drop_at=%0d",
             name, sel, init, tgt, n, abort_at, drop_at);
    @(negedge clock);
    load_req[sel] = 1'b1;
    load_val[sel] = W'(init);
    drop_idx[sel] = drop_at;
    @(negedge clock);
    load_req[sel] = 1'b0;
    start_s[sel]  = 1'b1;
    target_s[sel] = W'(tgt);
    aborted = 1'b0;
    for (int c = 0; c <= last && !aborted; c++) begin
      @(negedge clock);
      exp_en    = (c >= 1 && c <= n * p && (c % p) == 0) ? 1 : 0;
      exp_steps = (c >= 1 && c <= n * p) ? n - (c - 1) / p : 0;
      check_eq($sformatf("%s busy c=%0d", name, c),  32'(busy_o[sel]),  (c <= n * p + S) ? 1 : 0);
      check_eq($sformatf("%s en c=%0d", name, c),    32'(en_o[sel]),    exp_en);
      check_eq($sformatf("%s steps c=%0d", name, c), 32'(steps_o[sel]), exp_steps);
      check_eq($sformatf("%s done c=%0d", name, c),  32'(done_o[sel]),  (c == last) ? 1 : 0);
      check_eq($sformatf("%s err c=%0d", name, c),   32'(err_o[sel]),   (c == last) ? 32'(exp_err) : 0);
      if (!hold_start || c >= n * p) start_s[sel] = 1'b0;
      target_s[sel] = W'($urandom);
      if (c == abort_at) begin
        abort_s[sel] = 1'b1;
        start_s[sel] = 1'b1;
        @(negedge clock);
        abort_s[sel] = 1'b0;
        start_s[sel] = 1'b0;
        if (c <= n * p + S) begin
          check_idle(sel, $sformatf("%s abort+1", name));
          @(negedge clock);
          check_idle(sel, $sformatf("%s abort+2", name));
          check_eq($sformatf("%s abort err", name), 32'(err_o[sel]), 0);
          aborted = 1'b1;
        end
      end
    end
    if (!aborted) begin
      if (abort_at != last) @(negedge clock);
      check_idle(sel, $sformatf("%s post", name));
      check_eq($sformatf("%s final count", name), 32'(cnt[sel]), final_cnt);
      check_eq($sformatf("%s post err", name), 32'(err_o[sel]), 32'(exp_err));
    end
  endtask

  initial begin
    int sel, init, tgt, ab, dr, nn, pp, lst;
    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      abort_s[i]  = 1'b0;
      target_s[i] = '0;
      load_req[i] = 1'b0;
      load_val[i] = '0;
      drop_idx[i] = -1;
    end
    reset_N = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check_idle(i, $sformatf("reset%0d", i));
      check_eq($sformatf("reset%0d err", i), 32'(err_o[i]), 0);
    end
    reset_N = 1'b1;

    do_run(0, 3, 7, -1, -1, 1'b0, "t1_basic");
    do_run(0, 5, 5, -1, -1, 1'b1, "t2_fullrev");
    do_run(0, 14, 2, -1, -1, 1'b0, "t3_wrap");
    do_run(0, 0, 9, 9, -1, 1'b0, "t4_abort");
    do_run(0, 0, 3, -1, 1, 1'b0, "t5_drop");
    do_run(0, 6, 8, 11, -1, 1'b0, "t_abort_done");

    // abort beats a simultaneous start in IDLE
    @(negedge clock);
    start_s[0] = 1'b1; abort_s[0] = 1'b1; target_s[0] = 4'd5;
    @(negedge clock);
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    check_idle(0, "idle_abort+1");
    @(negedge clock);
    check_idle(0, "idle_abort+2");
    $display("txn idle start+abort");

    // asynchronous reset in the middle of a run
    @(negedge clock);
    load_req[0] = 1'b1; load_val[0] = 4'd1; drop_idx[0] = -1;
    @(negedge clock);
    load_req[0] = 1'b0; start_s[0] = 1'b1; target_s[0] = 4'd9;
    @(negedge clock);
    start_s[0] = 1'b0;
    repeat (11) @(negedge clock);
    check_eq("midrun busy before reset", 32'(busy_o[0]), 1);
    #2 reset_N = 1'b0;
    #1;
    check_idle(0, "async_reset");
    check_eq("async_reset err", 32'(err_o[0]), 0);
    @(negedge clock);
    reset_N = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check_idle(0, "after_reset");
    end
    $display("txn async reset mid-run");

    do_run(1, 0, 3, -1, -1, 1'b0, "t6_p1");

    for (int i = 0; i < 12; i++) begin
      sel  = int'($urandom_range(0, 1));
      init = int'($urandom_range(0, 15));
      tgt  = int'($urandom_range(0, 15));
      pp   = (sel == 0) ? 4 : 1;
      nn   = (tgt - init) & 15;
      if (nn == 0) nn = 16;
      lst  = nn * pp + S + 1;
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, lst)) : -1;
      dr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nn - 1)) : -1;
      do_run(sel, init, tgt, ab, dr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
